// File: rtl/divider_iterative.sv
// Multi-cycle restoring divider: one quotient bit per clock, operand latching, start/finished handshake.
// Optional signed (truncating) division is enabled by defining DIVIDER_SIGNED_EN.
module divider_iterative #(
    parameter int N = 8
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic         i_signed,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_finished,
    output logic [N-1:0] o_quotient,
    output logic [N-1:0] o_remainder,
    output logic         o_div_zero
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIVIDE = 2'd1;
    localparam logic [1:0] S_FIXUP  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int            CW     = $clog2(N);
    localparam logic [CW-1:0] LAST   = CW'(N - 1);
    localparam logic [CW-1:0] CNT_1  = CW'(1);
    localparam logic [N-1:0]  ONE    = N'(1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_dvd_shift;
    logic [N-1:0]  r_dvd_orig;
    logic [N-1:0]  r_divisor;
    logic [N-1:0]  r_partial;
    logic [N-1:0]  r_quot;
    logic          r_sign_q;
    logic          r_sign_r;
    logic          r_zero;
    logic [N-1:0]  r_quotient;
    logic [N-1:0]  r_remainder;
    logic          r_div_zero;

    logic          w_accept;
    logic          w_dvd_neg;
    logic          w_dvs_neg;
    logic [N-1:0]  w_dvd_mag;
    logic [N-1:0]  w_dvs_mag;
    logic [N:0]    w_window;
    logic [N+1:0]  w_trial;
    logic          w_borrow;
    logic [N-1:0]  w_quot_fix;
    logic [N-1:0]  w_rem_fix;

    assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef DIVIDER_SIGNED_EN
    assign w_dvd_neg  = i_signed & i_dividend[N-1];
    assign w_dvs_neg  = i_signed & i_divisor[N-1];
    assign w_dvd_mag  = w_dvd_neg ? (~i_dividend + ONE) : i_dividend;
    assign w_dvs_mag  = w_dvs_neg ? (~i_divisor + ONE) : i_divisor;
    assign w_quot_fix = r_sign_q ? (~r_quot + ONE) : r_quot;
    assign w_rem_fix  = r_sign_r ? (~r_partial + ONE) : r_partial;
`else
    // Unsigned-only build: mode input has no effect, sign flags stay clear.
    assign w_dvd_neg  = i_signed & 1'b0;
    assign w_dvs_neg  = 1'b0;
    assign w_dvd_mag  = i_dividend;
    assign w_dvs_mag  = i_divisor;
    assign w_quot_fix = r_sign_q ? r_quot : r_quot;
    assign w_rem_fix  = r_sign_r ? r_partial : r_partial;
`endif

    // The window keeps the partial remainder's MSB so divisors with their top bit set still work.
    assign w_window = {r_partial, r_dvd_shift[N-1]};
    assign w_trial  = {1'b0, w_window} - {2'b00, r_divisor};
    assign w_borrow = w_trial[N+1];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_dvd_shift <= '0;
            r_dvd_orig  <= '0;
            r_divisor   <= '0;
            r_partial   <= '0;
            r_quot      <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_zero      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_dvd_shift <= w_dvd_mag;
                        r_dvd_orig  <= i_dividend;
                        r_divisor   <= w_dvs_mag;
                        r_sign_q    <= w_dvd_neg ^ w_dvs_neg;
                        r_sign_r    <= w_dvd_neg;
                        r_zero      <= (i_divisor == '0);
                        r_count     <= '0;
                        r_partial   <= '0;
                        r_quot      <= '0;
                        r_state     <= S_DIVIDE;
                    end else begin
                        r_state     <= S_IDLE;
                    end
                end
                S_DIVIDE: begin
                    r_partial   <= w_borrow ? w_window[N-1:0] : w_trial[N-1:0];
                    r_quot      <= {r_quot[N-2:0], ~w_borrow};
                    r_dvd_shift <= {r_dvd_shift[N-2:0], 1'b0};
                    r_count     <= r_count + CNT_1;
                    if (r_count == LAST) begin
                        r_state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    // Divide-by-zero results bypass sign correction entirely.
                    r_quotient  <= r_zero ? '1 : w_quot_fix;
                    r_remainder <= r_zero ? r_dvd_orig : w_rem_fix;
                    r_div_zero  <= r_zero;
                    r_state     <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = (r_state == S_DIVIDE) || (r_state == S_FIXUP);
    assign o_finished  = (r_state == S_DONE);
    assign o_quotient  = r_quotient;
    assign o_remainder = r_remainder;
    assign o_div_zero  = r_div_zero;

endmodule

// File: tb/tb_divider_iterative.sv
// Directed and exhaustive checks of divider_iterative at N=8 and N=4.
// Signed expectations follow whether DIVIDER_SIGNED_EN is defined for the build.
module tb_divider_iterative;

    logic       clk;
    logic       reset;

    logic       start8, sgn8;
    logic [7:0] dvd8, dvs8;
    logic       busy8, fin8, z8;
    logic [7:0] q8, r8;

    logic       start4, sgn4;
    logic [3:0] dvd4, dvs4;
    logic       busy4, fin4, z4;
    logic [3:0] q4, r4;

    int n_checks = 0;
    int n_errors = 0;

    divider_iterative #(.N(8)) dut8 (
        .i_clock(clk), .i_reset(reset), .i_start(start8), .i_signed(sgn8),
        .i_dividend(dvd8), .i_divisor(dvs8), .o_busy(busy8), .o_finished(fin8),
        .o_quotient(q8), .o_remainder(r8), .o_div_zero(z8)
    );

    divider_iterative #(.N(4)) dut4 (
        .i_clock(clk), .i_reset(reset), .i_start(start4), .i_signed(sgn4),
        .i_dividend(dvd4), .i_divisor(dvs4), .o_busy(busy4), .o_finished(fin4),
        .o_quotient(q4), .o_remainder(r4), .o_div_zero(z4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one N=8 division, scramble operands after acceptance, return edges to o_finished.
    task automatic do_div8(input logic [7:0] a, input logic [7:0] b, input logic s, output int lat);
        @(negedge clk);
        start8 = 1'b1; dvd8 = a; dvs8 = b; sgn8 = s;
        @(posedge clk); #1;
        start8 = 1'b0; dvd8 = ~a; dvs8 = 8'($urandom); sgn8 = ~s;
        check("busy_after_accept", {31'd0, busy8}, 32'd1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (fin8) begin
                lat = k;
                break;
            end
        end
    endtask

    function automatic void model4(input int a, input int b, input bit s,
                                   output int q, output int r, output bit z);
        int sa, sb;
        bit eff;
`ifdef DIVIDER_SIGNED_EN
        eff = s;
`else
        eff = 1'b0;
`endif
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        z = 1'b0;
        if (b == 0) begin
            q = 15; r = a; z = 1'b1;
        end else if (eff) begin
            if (sa == -8 && sb == -1) begin
                q = 8; r = 0;
            end else begin
                q = (sa / sb) & 15;
                r = (sa % sb) & 15;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    int lat, t1, t2, fin_seen;
    int eq, er;
    bit ez;

    initial begin
        vecs[0]  = '{8'd100, 8'd7,   1'b0, 8'd14,  8'd2,   1'b0};
        vecs[1]  = '{8'd13,  8'd0,   1'b0, 8'hFF,  8'd13,  1'b1};
        vecs[2]  = '{8'd255, 8'd1,   1'b0, 8'hFF,  8'd0,   1'b0};
        vecs[3]  = '{8'd0,   8'd5,   1'b0, 8'd0,   8'd0,   1'b0};
        vecs[4]  = '{8'd50,  8'd5,   1'b0, 8'd10,  8'd0,   1'b0};
        vecs[5]  = '{8'd7,   8'd9,   1'b0, 8'd0,   8'd7,   1'b0};
        vecs[6]  = '{8'd255, 8'd255, 1'b0, 8'd1,   8'd0,   1'b0};
        vecs[7]  = '{8'd200, 8'd16,  1'b0, 8'd12,  8'd8,   1'b0};
        vecs[8]  = '{8'h85,  8'h00,  1'b1, 8'hFF,  8'h85,  1'b1};
`ifdef DIVIDER_SIGNED_EN
        vecs[9]  = '{8'hF9,  8'h02,  1'b1, 8'hFD,  8'hFF,  1'b0};
        vecs[10] = '{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0};
        vecs[11] = '{8'h07,  8'hFE,  1'b1, 8'hFD,  8'h01,  1'b0};
`else
        vecs[9]  = '{8'hF9,  8'h02,  1'b1, 8'd124, 8'd1,   1'b0};
        vecs[10] = '{8'h80,  8'hFF,  1'b1, 8'h00,  8'h80,  1'b0};
        vecs[11] = '{8'h07,  8'hFE,  1'b1, 8'h00,  8'h07,  1'b0};
`endif

        reset = 1'b1;
        start8 = 1'b0; sgn8 = 1'b0; dvd8 = '0; dvs8 = '0;
        start4 = 1'b0; sgn4 = 1'b0; dvd4 = '0; dvs4 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy8}, 32'd0);
        check("reset_finished", {31'd0, fin8}, 32'd0);
        check("reset_quotient", {24'd0, q8}, 32'd0);
        check("reset_remainder", {24'd0, r8}, 32'd0);
        check("reset_div_zero", {31'd0, z8}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table, N=8
        for (int i = 0; i < 12; i++) begin
            do_div8(vecs[i].a, vecs[i].b, vecs[i].s, lat);
            $display("txn vec%0d: %0h / %0h s=%0b -> q=%0h r=%0h z=%0b lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].s, q8, r8, z8, lat);
            check("vec_latency", lat, 32'd9);
            check("vec_busy_done", {31'd0, busy8}, 32'd0);
            check("vec_quotient", {24'd0, q8}, {24'd0, vecs[i].q});
            check("vec_remainder", {24'd0, r8}, {24'd0, vecs[i].r});
            check("vec_div_zero", {31'd0, z8}, {31'd0, vecs[i].z});
            @(posedge clk); #1;
            check("vec_finished_pulse", {31'd0, fin8}, 32'd0);
            check("vec_quotient_held", {24'd0, q8}, {24'd0, vecs[i].q});
        end

        // Back-to-back with ignored start pulse during DIVIDE
        @(negedge clk);
        start8 = 1'b1; dvd8 = 8'd50; dvs8 = 8'd5; sgn8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0; dvd8 = 8'd0; dvs8 = 8'd0;
        t1 = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                start8 = 1'b1; dvd8 = 8'd200; dvs8 = 8'd3;
            end else if (k == 4) begin
                start8 = 1'b0;
            end
            @(posedge clk); #1;
            if (fin8) begin
                t1 = k;
                break;
            end
        end
        $display("txn b2b first: 50 / 5 -> q=%0d r=%0d lat=%0d", q8, r8, t1);
        check("b2b_first_latency", t1, 32'd9);
        check("b2b_first_quotient", {24'd0, q8}, 32'd10);
        check("b2b_first_remainder", {24'd0, r8}, 32'd0);
        start8 = 1'b1; dvd8 = 8'd9; dvs8 = 8'd4;
        @(posedge clk); #1;
        start8 = 1'b0; dvd8 = 8'hAA; dvs8 = 8'h55;
        t2 = 0;
        for (int k = 2; k <= 25; k++) begin
            @(posedge clk); #1;
            if (fin8) begin
                t2 = k;
                break;
            end
        end
        $display("txn b2b second: 9 / 4 -> q=%0d r=%0d gap=%0d", q8, r8, t2);
        check("b2b_gap", t2, 32'd10);
        check("b2b_second_quotient", {24'd0, q8}, 32'd2);
        check("b2b_second_remainder", {24'd0, r8}, 32'd1);

        // Reset mid-DIVIDE abandons the operation
        @(negedge clk);
        start8 = 1'b1; dvd8 = 8'd100; dvs8 = 8'd7;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_busy", {31'd0, busy8}, 32'd0);
        check("midreset_finished", {31'd0, fin8}, 32'd0);
        check("midreset_quotient", {24'd0, q8}, 32'd0);
        check("midreset_remainder", {24'd0, r8}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        fin_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (fin8) fin_seen++;
        end
        check("midreset_no_finish", fin_seen, 32'd0);
        $display("txn midreset: finished pulses after reset=%0d", fin_seen);

        // Reset wins over a simultaneous start
        @(negedge clk);
        reset = 1'b1; start8 = 1'b1; dvd8 = 8'd9; dvs8 = 8'd3;
        @(posedge clk); #1;
        check("reset_priority_busy", {31'd0, busy8}, 32'd0);
        @(negedge clk);
        reset = 1'b0; start8 = 1'b0;

        do_div8(8'd100, 8'd7, 1'b0, lat);
        $display("txn after reset: 100 / 7 -> q=%0d r=%0d lat=%0d", q8, r8, lat);
        check("post_reset_latency", lat, 32'd9);
        check("post_reset_quotient", {24'd0, q8}, 32'd14);
        check("post_reset_remainder", {24'd0, r8}, 32'd2);

        // Exhaustive N=4 sweep in both modes
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    model4(a, b, m[0], eq, er, ez);
                    @(negedge clk);
                    start4 = 1'b1; dvd4 = 4'(a); dvs4 = 4'(b); sgn4 = m[0];
                    @(posedge clk); #1;
                    start4 = 1'b0; dvd4 = 4'($urandom); dvs4 = 4'($urandom); sgn4 = ~sgn4;
                    lat = 0;
                    for (int k = 1; k <= 10; k++) begin
                        @(posedge clk); #1;
                        if (fin4) begin
                            lat = k;
                            break;
                        end
                    end
                    $display("txn n4 s=%0d: %0d / %0d -> q=%0d r=%0d z=%0b lat=%0d",
                             m, a, b, q4, r4, z4, lat);
                    check("n4_latency", lat, 32'd5);
                    check("n4_quotient", {28'd0, q4}, eq);
                    check("n4_remainder", {28'd0, r4}, er);
                    check("n4_div_zero", {31'd0, z4}, {31'd0, ez});
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
